// File: rtl/debug_cmd_port_if.sv
// Byte-stream and register-file debug bus between host bridge, core and debug_cmd_port.
// rx/tx follow valid/ready: a byte moves on a clock edge where valid & ready are both high; valid holds data stable until then.
interface debug_cmd_port_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        dbg_halt;
  logic        dbg_halted;
  logic [4:0]  dbg_raddr;
  logic [31:0] dbg_rdata;
  logic        dbg_we;
  logic [4:0]  dbg_waddr;
  logic [31:0] dbg_wdata;

  // Responder side.
  modport slave (
    input  rx_data, rx_valid, tx_ready, dbg_halted, dbg_rdata,
    output rx_ready, tx_data, tx_valid, dbg_halt, dbg_raddr, dbg_we, dbg_waddr, dbg_wdata
  );

  // Host bridge plus core side.
  modport master (
    output rx_data, rx_valid, tx_ready, dbg_halted, dbg_rdata,
    input  rx_ready, tx_data, tx_valid, dbg_halt, dbg_raddr, dbg_we, dbg_waddr, dbg_wdata
  );
endinterface

// File: rtl/debug_cmd_port.sv
// Debug command responder: decodes host command bytes, halts/resumes the core and
// reads/writes register-file entries, answering with response bytes.
module debug_cmd_port #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  debug_cmd_port_if.slave  bus,
  output logic [2:0]       fsm_state
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_CAPTURE,
    S_GET_DATA,
    S_DO_WRITE,
    S_WAIT_HALT,
    S_SEND
  } state_t;

  localparam logic [2:0] OP_READ   = 3'b001;
  localparam logic [2:0] OP_WRITE  = 3'b010;
  localparam logic [2:0] OP_HALT   = 3'b100;
  localparam logic [2:0] OP_RESUME = 3'b101;
  localparam logic [7:0] RESP_OK   = 8'hAA;
  localparam logic [7:0] RESP_ERR  = 8'hEE;
  localparam int         TW        = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_t        state;
  logic [2:0]    op_q;
  logic [4:0]    addr_q;
  logic [1:0]    cnt;
  logic [TW-1:0] timer;
  logic [23:0]   shreg;
  logic [1:0]    left;
  logic          we_phase;
  logic          write_ok;
  logic          rx_fire;
  logic          tx_fire;

  assign rx_fire   = bus.rx_valid & bus.rx_ready;
  assign tx_fire   = bus.tx_valid & bus.tx_ready;
  assign fsm_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      op_q          <= '0;
      addr_q        <= '0;
      cnt           <= '0;
      timer         <= '0;
      shreg         <= '0;
      left          <= '0;
      we_phase      <= 1'b0;
      write_ok      <= 1'b0;
      bus.rx_ready  <= 1'b0;
      bus.tx_data   <= '0;
      bus.tx_valid  <= 1'b0;
      bus.dbg_halt  <= 1'b0;
      bus.dbg_raddr <= '0;
      bus.dbg_we    <= 1'b0;
      bus.dbg_waddr <= '0;
      bus.dbg_wdata <= '0;
    end else begin
      bus.dbg_we <= 1'b0;
      case (state)
        S_IDLE: begin
          bus.rx_ready <= 1'b1;
          if (rx_fire) begin
            bus.rx_ready <= 1'b0;
            op_q         <= bus.rx_data[7:5];
            addr_q       <= bus.rx_data[4:0];
            if (bus.rx_data[7:5] == OP_READ) bus.dbg_raddr <= bus.rx_data[4:0];
            state        <= S_DECODE;
          end
        end

        S_DECODE: begin
          case (op_q)
            OP_READ: begin
              if (bus.dbg_halted) begin
                state <= S_CAPTURE;
              end else begin
                bus.tx_valid <= 1'b1;
                bus.tx_data  <= RESP_ERR;
                left         <= 2'd0;
                state        <= S_SEND;
              end
            end
            // Data bytes are collected even when not halted so the command is fully consumed.
            OP_WRITE: begin
              cnt           <= 2'd0;
              timer         <= '0;
              bus.rx_ready  <= 1'b1;
              bus.dbg_waddr <= addr_q;
              state         <= S_GET_DATA;
            end
            OP_HALT: begin
              bus.dbg_halt <= 1'b1;
              state        <= S_WAIT_HALT;
            end
            OP_RESUME: begin
              bus.dbg_halt <= 1'b0;
              bus.tx_valid <= 1'b1;
              bus.tx_data  <= RESP_OK;
              left         <= 2'd0;
              state        <= S_SEND;
            end
            default: begin
              bus.tx_valid <= 1'b1;
              bus.tx_data  <= RESP_ERR;
              left         <= 2'd0;
              state        <= S_SEND;
            end
          endcase
        end

        S_CAPTURE: begin
          bus.tx_valid <= 1'b1;
          bus.tx_data  <= bus.dbg_rdata[7:0];
          shreg        <= bus.dbg_rdata[31:8];
          left         <= 2'd3;
          state        <= S_SEND;
        end

        S_GET_DATA: begin
          if (rx_fire) begin
            bus.dbg_wdata[{cnt, 3'b000} +: 8] <= bus.rx_data;
            timer <= '0;
            cnt   <= cnt + 2'd1;
            if (cnt == 2'd3) begin
              bus.rx_ready <= 1'b0;
              we_phase     <= 1'b0;
              state        <= S_DO_WRITE;
            end
          end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
            // Host went quiet: drop the partial write, rx_ready stays high for the next opcode.
            state <= S_IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        // Two cycles: strobe dbg_we, then launch the response one cycle behind it.
        S_DO_WRITE: begin
          if (!we_phase) begin
            we_phase   <= 1'b1;
            write_ok   <= bus.dbg_halted;
            bus.dbg_we <= bus.dbg_halted && (addr_q != 5'd0);
          end else begin
            bus.tx_valid <= 1'b1;
            bus.tx_data  <= write_ok ? RESP_OK : RESP_ERR;
            left         <= 2'd0;
            state        <= S_SEND;
          end
        end

        S_WAIT_HALT: begin
          if (bus.dbg_halted) begin
            bus.tx_valid <= 1'b1;
            bus.tx_data  <= RESP_OK;
            left         <= 2'd0;
            state        <= S_SEND;
          end
        end

        S_SEND: begin
          if (tx_fire) begin
            if (left == 2'd0) begin
              bus.tx_valid <= 1'b0;
              bus.rx_ready <= 1'b1;
              state        <= S_IDLE;
            end else begin
              bus.tx_data <= shreg[7:0];
              shreg       <= {8'h00, shreg[23:8]};
              left        <= left - 2'd1;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_cmd_port.sv
// Randomized bench for debug_cmd_port: a command-level model predicts response bytes and
// register writes, a simple core model answers halt requests and serves register reads.
module tb_debug_cmd_port;
  localparam int TIMEOUT_CYCLES = 1024;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  debug_cmd_port_if ifc ();
  logic [2:0] fsm_state;

  debug_cmd_port #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (ifc.slave),
    .fsm_state (fsm_state)
  );

  // ---------------- model / scoreboard state ----------------
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_q[$];
  logic [36:0] wq[$];
  logic [31:0] core_rf[32];
  logic [31:0] model_rf[32];
  logic [31:0] model_wdata = '0;
  bit          model_halt = 1'b0;
  int          tx_mode = 0;
  int          halt_delay = 5;
  int          hcnt = 0;

  assign ifc.dbg_rdata = core_rf[ifc.dbg_raddr];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
    end
  endtask

  // tx_ready pattern and core halt behaviour, updated just after each rising edge.
  initial begin
    ifc.tx_ready   = 1'b0;
    ifc.dbg_halted = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (tx_mode)
        0:       ifc.tx_ready = 1'b1;
        1:       ifc.tx_ready = ~ifc.tx_ready;
        2:       ifc.tx_ready = 1'($urandom_range(0, 1));
        default: ifc.tx_ready = 1'b0;
      endcase
      if (ifc.dbg_halt) begin
        if (!ifc.dbg_halted) begin
          if (hcnt >= halt_delay) ifc.dbg_halted = 1'b1;
          else hcnt++;
        end
      end else begin
        ifc.dbg_halted = 1'b0;
        hcnt = 0;
      end
    end
  end

  // Scoreboard: every transferred byte and every write strobe must be predicted.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ifc.tx_valid && ifc.tx_ready) begin
        check("tx_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check("tx_byte", ifc.tx_data, exp_q.pop_front());
      end
      if (ifc.dbg_we) begin
        check("we_expected", wq.size() > 0, 1);
        if (wq.size() > 0) check("we_addr_data", {ifc.dbg_waddr, ifc.dbg_wdata}, wq.pop_front());
        if (ifc.dbg_waddr != 5'd0) core_rf[ifc.dbg_waddr] = ifc.dbg_wdata;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    ifc.rx_data  = b;
    ifc.rx_valid = 1'b1;
    while (!ifc.rx_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("rx_accept_bound", n < 500, 1);
    @(negedge clk);
    ifc.rx_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || wq.size() != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("drain", exp_q.size() + wq.size(), 0);
    @(negedge clk);
  endtask

  // Predict the outcome of one command from its meaning, then issue it and wait for the answer.
  task automatic do_cmd(input logic [7:0] opc, input logic [31:0] data);
    logic [2:0]  op;
    logic [4:0]  a;
    logic [31:0] v;
    op = opc[7:5];
    a  = opc[4:0];
    case (op)
      3'b001: begin
        if (model_halt) begin
          v = model_rf[a];
          for (int k = 0; k < 4; k++) exp_q.push_back(v[8*k +: 8]);
        end else exp_q.push_back(8'hEE);
      end
      3'b010: begin
        if (model_halt) begin
          if (a != 5'd0) begin
            wq.push_back({a, data});
            model_rf[a] = data;
          end
          exp_q.push_back(8'hAA);
        end else exp_q.push_back(8'hEE);
      end
      3'b100: begin model_halt = 1'b1; exp_q.push_back(8'hAA); end
      3'b101: begin model_halt = 1'b0; exp_q.push_back(8'hAA); end
      default: exp_q.push_back(8'hEE);
    endcase
    send_byte(opc);
    if (op == 3'b010) begin
      for (int k = 0; k < 4; k++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        send_byte(data[8*k +: 8]);
        model_wdata[8*k +: 8] = data[8*k +: 8];
      end
    end
    wait_drain();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_ready"}, ifc.rx_ready, 0);
    check({tag, "_tx_valid"}, ifc.tx_valid, 0);
    check({tag, "_tx_data"},  ifc.tx_data, 0);
    check({tag, "_dbg_halt"}, ifc.dbg_halt, 0);
    check({tag, "_dbg_we"},   ifc.dbg_we, 0);
    check({tag, "_raddr"},    ifc.dbg_raddr, 0);
    check({tag, "_waddr"},    ifc.dbg_waddr, 0);
    check({tag, "_wdata"},    ifc.dbg_wdata, 0);
  endtask

  task automatic mid_reset(input string tag);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs(tag);
    model_halt  = 1'b0;
    model_wdata = '0;
    exp_q.delete();
    wq.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check({tag, "_rx_ready_after"}, ifc.rx_ready, 1);
  endtask

  // Watchdog so the bench always terminates.
  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0]  opc;
    logic [31:0] d;
    int          r;
    int          n;
    ifc.rx_data  = '0;
    ifc.rx_valid = 1'b0;
    for (int i = 0; i < 32; i++) core_rf[i] = (i == 0) ? 32'h0 : $urandom;
    for (int i = 0; i < 32; i++) model_rf[i] = core_rf[i];

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check("rx_ready_after_reset", ifc.rx_ready, 1);

    // HALT with the core draining for a few cycles.
    exp_q.push_back(8'hAA);
    model_halt = 1'b1;
    send_byte(8'h80);
    @(negedge clk);
    check("halt_at_n2", ifc.dbg_halt, 1);
    n = 0;
    while (!ifc.dbg_halted && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("halted_bound", n < 100, 1);
    check("halt_ack_not_early", ifc.tx_valid, 0);
    @(negedge clk);
    check("halt_ack_valid", ifc.tx_valid, 1);
    check("halt_ack_data", ifc.tx_data, 8'hAA);
    wait_drain();

    // WRITE x5 with exact strobe timing.
    wq.push_back({5'd5, 32'h12345678});
    model_rf[5] = 32'h12345678;
    exp_q.push_back(8'hAA);
    send_byte(8'h45);
    send_byte(8'h78);
    send_byte(8'h56);
    send_byte(8'h34);
    send_byte(8'h12);
    model_wdata = 32'h12345678;
    check("wr_n1_we", ifc.dbg_we, 0);
    check("wr_n1_waddr", ifc.dbg_waddr, 5);
    check("wr_n1_wdata", ifc.dbg_wdata, 32'h12345678);
    @(negedge clk);
    check("wr_n2_we", ifc.dbg_we, 1);
    check("wr_n2_wdata", ifc.dbg_wdata, 32'h12345678);
    check("wr_n2_tx_valid", ifc.tx_valid, 0);
    @(negedge clk);
    check("wr_n3_we", ifc.dbg_we, 0);
    check("wr_n3_tx_valid", ifc.tx_valid, 1);
    wait_drain();

    // READ x5 under a toggling tx_ready.
    core_rf[5]  = 32'hDEADBEEF;
    model_rf[5] = 32'hDEADBEEF;
    tx_mode = 1;
    exp_q.push_back(8'hEF);
    exp_q.push_back(8'hBE);
    exp_q.push_back(8'hAD);
    exp_q.push_back(8'hDE);
    send_byte(8'h25);
    check("rd_n1_raddr", ifc.dbg_raddr, 5);
    check("rd_n1_tx_valid", ifc.tx_valid, 0);
    @(negedge clk);
    check("rd_n2_tx_valid", ifc.tx_valid, 0);
    @(negedge clk);
    check("rd_n3_tx_valid", ifc.tx_valid, 1);
    check("rd_n3_tx_data", ifc.tx_data, 8'hEF);
    wait_drain();
    tx_mode = 0;

    // RESUME answers without waiting for the core.
    exp_q.push_back(8'hAA);
    model_halt = 1'b0;
    send_byte(8'hA0);
    @(negedge clk);
    check("resume_n2_halt", ifc.dbg_halt, 0);
    check("resume_n2_tx_valid", ifc.tx_valid, 1);
    wait_drain();

    do_cmd(8'h43, $urandom);        // write while running -> EE
    do_cmd(8'h80, 32'h0);           // halt
    do_cmd(8'h40, 32'hCAFEF00D);    // write x0 -> AA, no strobe
    do_cmd(8'hE0, 32'h0);           // bad opcode -> EE

    // Partial WRITE abandoned by timeout.
    send_byte(8'h46);
    send_byte(8'h11);
    model_wdata[7:0] = 8'h11;
    send_byte(8'h22);
    model_wdata[15:8] = 8'h22;
    repeat (TIMEOUT_CYCLES + 5) @(negedge clk);
    check("timeout_wdata_kept", ifc.dbg_wdata, model_wdata);
    check("timeout_no_tx", ifc.tx_valid, 0);
    do_cmd(8'h26, 32'h0);

    // Randomized command mix.
    for (int i = 0; i < 40; i++) begin
      tx_mode    = $urandom_range(0, 2);
      halt_delay = $urandom_range(0, 6);
      r = $urandom_range(0, 9);
      d = $urandom;
      opc = 8'($urandom);
      if (r <= 2)      opc[7:5] = 3'b001;
      else if (r <= 5) opc[7:5] = 3'b010;
      else if (r == 6) opc[7:5] = 3'b100;
      else if (r == 7) opc[7:5] = 3'b101;
      do_cmd(opc, d);
    end
    tx_mode    = 0;
    halt_delay = 5;

    // Reset while waiting for the core to halt.
    do_cmd(8'hA0, 32'h0);
    halt_delay = 100000;
    send_byte(8'h80);
    repeat (4) @(negedge clk);
    mid_reset("rst_wait_halt");
    halt_delay = 2;

    // Reset while a READ response is stalled by the host.
    do_cmd(8'h80, 32'h0);
    tx_mode = 3;
    @(negedge clk);
    send_byte(8'h27);
    n = 0;
    while (!ifc.tx_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("stalled_read_valid", ifc.tx_valid, 1);
    mid_reset("rst_send");
    tx_mode = 0;
    repeat (20) @(negedge clk);
    check("post_reset_no_tx", ifc.tx_valid, 0);
    do_cmd(8'h21, 32'h0);           // halt was cleared by reset -> EE

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/debug_cmd_port.md
# debug_cmd_port

Host-side debug command responder for the rv32 pipeline; it is the write/control counterpart of the read-only register debug port. It accepts a byte stream of commands over a valid/ready receive interface. It halts and resumes the core, reads and writes register-file entries through a dedicated debug port, and returns response bytes over a valid/ready transmit interface. It sits between a UART/JTAG byte bridge and the core's stall input and register-file debug ports.

## Interface
- TIMEOUT_CYCLES, 1024: idle cycles allowed between bytes of a write command before it is discarded.
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rx_data  in  8  command byte from host.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  block can accept a byte; transfer when rx_valid & rx_ready.
- tx_data  out  8  response byte to host.
- tx_valid  out  1  tx_data valid; held with data stable until accepted.
- tx_ready  in  1  host accepts; transfer when tx_valid & tx_ready.
- dbg_halt  out  1  stall request to the core, level.
- dbg_halted  in  1  core is stalled (pipeline drained).
- dbg_raddr  out  5  register-file debug read address, registered.
- dbg_rdata  in  32  combinational read data for dbg_raddr.
- dbg_we  out  1  register-file debug write strobe, one-cycle pulse.
- dbg_waddr  out  5  write address.
- dbg_wdata  out  32  write data.

## Operation
- Opcode byte = {op[2:0], addr[4:0]}.
  - op 001 READ addr
  - op 010 WRITE addr, followed by 4 data bytes, little-endian
  - op 100 HALT
  - op 101 RESUME
  - any other op: respond 0xEE.
- Responses:
  - READ: 4 bytes of the register, little-endian.
  - WRITE, HALT, RESUME: 0xAA.
  - Error: 0xEE.
- READ or WRITE while dbg_halted=0: consume the full command (4 data bytes for WRITE), perform no access, respond 0xEE.
- WRITE to addr 0: dbg_we is not pulsed; respond 0xAA.
- HALT: set dbg_halt=1, wait for dbg_halted=1 with no timeout, then respond 0xAA. If dbg_halted is already 1, respond immediately.
- RESUME: clear dbg_halt, respond 0xAA without waiting for dbg_halted to fall.
- States:
  - IDLE: rx_ready=1. Opcode accepted -> DECODE.
  - DECODE: READ -> CAPTURE; WRITE -> GET_DATA with cnt=0; HALT -> WAIT_HALT; RESUME and errors -> SEND.
  - CAPTURE: latch dbg_rdata into the 32-bit shift register -> SEND, 4 bytes.
  - GET_DATA: rx_ready=1. Shift each byte into dbg_wdata[8*cnt+:8]. After cnt=3 -> DO_WRITE. Idle timeout -> IDLE with no response.
  - DO_WRITE: pulse dbg_we (if halted and addr != 0) -> SEND, 1 byte.
  - WAIT_HALT -> SEND once dbg_halted=1.
  - SEND: present bytes LSB first; after the last byte is accepted -> IDLE.
- rx_ready=0 in every state except IDLE and GET_DATA; this gives backpressure on the host.
- Idle timer: reset on each accepted byte in GET_DATA. When it reaches TIMEOUT_CYCLES, discard the partial command and keep dbg_wdata at its last value.
- dbg_halt is unaffected by READ, WRITE, error commands and timeouts.

## Timing
- Reset values: rx_ready=0, tx_valid=0, tx_data=0, dbg_halt=0, dbg_we=0, dbg_raddr=0, dbg_waddr=0, dbg_wdata=0; state IDLE.
  - rx_ready rises in the first cycle after rst_n deasserts.
- Reset mid-command: abandon the command, drop any pending response, clear dbg_halt asynchronously.
- READ latency: opcode accepted in cycle N; dbg_raddr valid in N+1; data captured at the end of N+2; tx_valid first asserted in N+3.
- WRITE: last data byte accepted in cycle N; dbg_we=1 in N+2 for exactly one cycle, with dbg_waddr and dbg_wdata stable from N+1 through N+2; 0xAA tx_valid in N+3.
- HALT: dbg_halt=1 from N+2. 0xAA tx_valid asserts 1 cycle after dbg_halted is first sampled high.
- RESUME: dbg_halt=0 from N+2; 0xAA tx_valid in N+2.
- tx handshake: the byte advances only on tx_valid & tx_ready. tx_ready held low stalls indefinitely with no loss. tx_valid stays high across back-to-back bytes when tx_ready=1.
- Command throughput: at most one command in flight; the next opcode is accepted the cycle after the last response byte transfers.

## Test plan
- Reset, then send 0x80 (HALT) with dbg_halted rising 5 cycles later -> dbg_halt=1 from N+2; single 0xAA after dbg_halted.
- Halted, send 0x45, 0x78, 0x56, 0x34, 0x12 (WRITE x5) -> one dbg_we pulse with waddr=5, wdata=0x12345678; then 0xAA.
- Halted, send 0x25 (READ x5) with dbg_rdata=0xDEADBEEF -> bytes EF, BE, AD, DE; tx_ready toggling every other cycle, no bytes lost or duplicated.
- Not halted, send 0x43 plus 4 data bytes -> no dbg_we, response 0xEE. Halted, WRITE to x0 -> no dbg_we, 0xAA. Opcode 0xE0 -> 0xEE.
- WRITE opcode plus 2 data bytes then silence for TIMEOUT_CYCLES -> return to IDLE, no response, no dbg_we. Next READ is handled normally.
- Assert rst_n low during WAIT_HALT and during SEND of a READ -> all outputs at reset values immediately; dbg_halt=0; no stale tx byte after reset.
